// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S bus master and stereo transmitter.
// Derives bit_clk / lr_clk from clk, serializes one coherent left/right frame
// per 2*SLOT_W bit periods, and accepts frames through a one-entry holding
// register. An empty holding register at frame start sends a zero frame and
// pulses underrun.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds an 8-bit saturating
// underrun_cnt output.
module i2s_master_tx #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                bit_clk,
    output logic                lr_clk,
    output logic                sd,
    output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]          underrun_cnt
`endif
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int PW      = $clog2(FRAME_W);
    localparam int CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(FRAME_W - 1);

    logic [CW-1:0]       div_q, div_d;
    logic                bit_clk_q, bit_clk_d;
    logic [PW-1:0]       p_q, p_d;
    logic                lr_q, lr_d;
    logic                sd_q, sd_d;
    logic                ur_q, ur_d;
    logic                ready_q, ready_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_left_q, hold_left_d;
    logic [SAMPLE_W-1:0] hold_right_q, hold_right_d;
    logic [SAMPLE_W-1:0] left_sh_q, left_sh_d;
    logic [SAMPLE_W-1:0] right_sh_q, right_sh_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0]          cnt_q, cnt_d;
`endif

    logic                div_wrap, fall, frame_start, xfer, right_slot;
    logic [PW-1:0]       p_nxt;
    logic [31:0]         pos;
    logic [SAMPLE_W-1:0] load_left, load_right;

    // Divider, position counter, serializer and handshake next-state logic.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        div_d        = div_q;
        bit_clk_d    = bit_clk_q;
        p_d          = p_q;
        lr_d         = lr_q;
        sd_d         = sd_q;
        ur_d         = 1'b0;
        left_sh_d    = left_sh_q;
        right_sh_d   = right_sh_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;

        div_wrap    = (div_q == DIV_LAST);
        fall        = div_wrap && bit_clk_q;
        frame_start = fall && (p_q == '0);
        p_nxt       = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        pos         = 32'(p_nxt);
        load_left   = hold_full_q ? hold_left_q  : '0;
        load_right  = hold_full_q ? hold_right_q : '0;
        // Right bits occupy SLOT_W+1.. ; with a full-width sample the LSB
        // wraps into position 0 of the following frame.
        right_slot  = ((pos >= 32'(SLOT_W + 1)) && (pos <= 32'(SLOT_W + SAMPLE_W)))
                    || ((SAMPLE_W == SLOT_W) && (pos == 32'd0));

        div_d = div_wrap ? '0 : div_q + CW'(1);
        if (div_wrap) begin
            bit_clk_d = ~bit_clk_q;
        end

        if (fall) begin
            p_d  = p_nxt;
            lr_d = (pos >= 32'(SLOT_W - 1)) && (pos <= 32'(2 * SLOT_W - 2));
            sd_d = 1'b0;
            if (frame_start) begin
                // Both channels load together so a frame is never torn.
                sd_d       = load_left[SAMPLE_W-1];
                left_sh_d  = load_left << 1;
                right_sh_d = load_right;
                ur_d       = !hold_full_q;
            end else if ((pos >= 32'd2) && (pos <= 32'(SAMPLE_W))) begin
                sd_d      = left_sh_q[SAMPLE_W-1];
                left_sh_d = left_sh_q << 1;
            end else if (right_slot) begin
                sd_d       = right_sh_q[SAMPLE_W-1];
                right_sh_d = right_sh_q << 1;
            end
        end

        // No bypass: a frame accepted on a frame-start cycle waits a frame.
        xfer        = in_valid && ready_q;
        hold_full_d = xfer ? 1'b1 : (frame_start ? 1'b0 : hold_full_q);
        ready_d     = !hold_full_d;
        if (xfer) begin
            hold_left_d  = in_left;
            hold_right_d = in_right;
        end

`ifdef I2S_TX_UNDERRUN_CNT_EN
        cnt_d = (ur_d && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
`endif
    end

    // Control and serializer state; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            bit_clk_q   <= 1'b0;
            p_q         <= P_LAST;
            lr_q        <= 1'b0;
            sd_q        <= 1'b0;
            ur_q        <= 1'b0;
            ready_q     <= 1'b1;
            hold_full_q <= 1'b0;
            left_sh_q   <= '0;
            right_sh_q  <= '0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            div_q       <= div_d;
            bit_clk_q   <= bit_clk_d;
            p_q         <= p_d;
            lr_q        <= lr_d;
            sd_q        <= sd_d;
            ur_q        <= ur_d;
            ready_q     <= ready_d;
            hold_full_q <= hold_full_d;
            left_sh_q   <= left_sh_d;
            right_sh_q  <= right_sh_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Holding-register payload; its contents only matter while hold_full_q is set.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; hold_full_q qualifies it, and
        // leaving it out of reset keeps it off the reset tree.
        hold_left_q  <= hold_left_d;
        hold_right_q <= hold_right_d;
    end

    assign bit_clk  = bit_clk_q;
    assign lr_clk   = lr_q;
    assign sd       = sd_q;
    assign underrun = ur_q;
    assign in_ready = ready_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    assign underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_i2s_master_tx.sv
// tb_i2s_master_tx: self-checking bench for i2s_master_tx.
// A reference model derives every expected output from the count of clk
// edges since reset release; a receiver-style monitor rebuilds frames from
// the serial line for table-driven and hand-written frame checks.
module tb_i2s_master_tx;

    localparam int SW  = 24;
    localparam int SL  = 32;
    localparam int DIV = 2;
    localparam int FB  = 2 * SL;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_left;
    logic [SW-1:0] in_right;
    logic          bit_clk;
    logic          lr_clk;
    logic          sd;
    logic          underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0]    underrun_cnt;
`endif

    i2s_master_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_left  (in_left),
        .in_right (in_right),
        .bit_clk  (bit_clk),
        .lr_clk   (lr_clk),
        .sd       (sd),
        .underrun (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    // Reference model state.
    int            n;
    bit            m_full, m_ready, m_ur;
    logic [SW-1:0] m_hl, m_hr, m_cl, m_cr;
    int            m_cnt;

    // Frame monitor state.
    bit            mon_prev, mon_ur;
    int            mon_j, mon_count;
    logic [SW-1:0] mon_l, mon_r;
    logic [SW-1:0] fr_l [64];
    logic [SW-1:0] fr_r [64];
    bit            fr_ur [64];

    typedef struct {
        bit            valid;
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic [SW-1:0] exp_l;
        logic [SW-1:0] exp_r;
        bit            exp_ur;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    function automatic int exp_p();
        if (n < 2 * DIV) return FB - 1;
        return (n / (2 * DIV) - 1) % FB;
    endfunction

    function automatic bit exp_bclk();
        return ((n / DIV) % 2) == 1;
    endfunction

    function automatic bit exp_lr();
        int p;
        p = exp_p();
        return (p >= SL - 1) && (p <= 2 * SL - 2);
    endfunction

    function automatic bit exp_sd();
        int p, k;
        p = exp_p();
        if (p >= 1 && p <= SW) return m_cl[SW - p];
        k = (p + FB - SL - 1) % FB;
        if (k < SW) return m_cr[SW - 1 - k];
        return 1'b0;
    endfunction

    task automatic model_reset();
        n = 0; m_full = 0; m_ready = 1; m_ur = 0;
        m_cl = '0; m_cr = '0; m_hl = '0; m_hr = '0; m_cnt = 0;
        mon_prev = 0; mon_ur = 0; mon_j = 0; mon_count = 0;
        mon_l = '0; mon_r = '0;
    endtask

    // Advance the model across one rising clk edge.
    task automatic model_step();
        bit xfer;
        n++;
        xfer = in_valid && m_ready;
        m_ur = 0;
        if ((n % (2 * DIV) == 0) && (exp_p() == 1)) begin
            if (m_full) begin
                m_cl = m_hl; m_cr = m_hr;
            end else begin
                m_cl = '0; m_cr = '0; m_ur = 1;
                if (m_cnt < 255) m_cnt++;
            end
            m_full = 0;
        end
        if (xfer) begin
            m_full = 1; m_hl = in_left; m_hr = in_right;
        end
        m_ready = !m_full;
    endtask

    task automatic compare_all();
        check("outputs{bclk,lr,sd,ready,underrun}",
              {27'd0, bit_clk, lr_clk, sd, in_ready, underrun},
              {27'd0, exp_bclk(), exp_lr(), exp_sd(), m_ready, m_ur});
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
    endtask

    // Receiver: sample sd on bit_clk rises and rebuild frames.
    task automatic monitor_step();
        int p;
        if (underrun) mon_ur = 1;
        if (!mon_prev && bit_clk) begin
            mon_j++;
            p = (mon_j + FB - 2) % FB;
            if (p >= 1 && p <= SW) mon_l = {mon_l[SW-2:0], sd};
            if (p >= SL + 1 && p <= SL + SW) mon_r = {mon_r[SW-2:0], sd};
            if (p == SL + SW) begin
                if (mon_count < 64) begin
                    fr_l[mon_count]  = mon_l;
                    fr_r[mon_count]  = mon_r;
                    fr_ur[mon_count] = mon_ur;
                end
                mon_count++;
                mon_ur = 0;
            end
        end
        mon_prev = bit_clk;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
        monitor_step();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int limit);
        int c;
        c = 0;
        while (mon_count < target && c < limit) begin
            tick();
            c++;
        end
        if (mon_count < target) timeout($sformatf("wait_frame%0d", target - 1));
    endtask

    task automatic wait_ready(input int limit);
        int c;
        c = 0;
        while (!in_ready && c < limit) begin
            tick();
            c++;
        end
        if (!in_ready) timeout("wait_in_ready");
    endtask

    task automatic check_frame(input int idx, input logic [SW-1:0] l,
                               input logic [SW-1:0] r, input bit ur);
        check($sformatf("frame%0d_left", idx),     32'(fr_l[idx]),  32'(l));
        check($sformatf("frame%0d_right", idx),    32'(fr_r[idx]),  32'(r));
        check($sformatf("frame%0d_underrun", idx), 32'(fr_ur[idx]), 32'(ur));
    endtask

    // Reset release timing plus one prefilled frame.
    task automatic startup_seq();
        int rise, fall, sd_first;
        rise = -1; fall = -1; sd_first = -1;
        in_valid = 1'b1;
        in_left  = 24'hA5F00F;
        in_right = 24'h800001;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 1) in_valid = 1'b0;
            if (bit_clk && rise < 0) rise = e;
            if (!bit_clk && rise > 0 && fall < 0) fall = e;
            if (sd && sd_first < 0) sd_first = e;
        end
        check("first_bclk_rise_edge", rise, 2);
        check("first_bclk_fall_edge", fall, 4);
        check("first_sd_high_edge", sd_first, 8);
        wait_frames(1, 400);
        check_frame(0, 24'hA5F00F, 24'h800001, 1'b0);
    endtask

    initial begin
        vec_t tbl[5];
        int   rd, cnt, idx, ready_hi, c;
        bit   will_xfer;

        checks = 0; failures = 0;
        in_valid = 1'b0; in_left = '0; in_right = '0; rst_n = 1'b0;
        model_reset();

        tbl[0] = '{1'b0, 24'h123456, 24'h654321, 24'h000000, 24'h000000, 1'b1};
        tbl[1] = '{1'b1, 24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 1'b0};
        tbl[2] = '{1'b1, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1'b0};
        tbl[3] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000, 1'b1};
        tbl[4] = '{1'b1, 24'hC3C3C3, 24'h3C3C3C, 24'hC3C3C3, 24'h3C3C3C, 1'b0};

        // Startup and prefilled frame, then table-driven frames.
        apply_reset();
        startup_seq();
        rd = 1;
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].valid) begin
                wait_ready(300);
                in_valid = 1'b1;
                in_left  = tbl[i].l;
                in_right = tbl[i].r;
                tick();
                in_valid = 1'b0;
            end else begin
                in_left  = tbl[i].l;
                in_right = tbl[i].r;
            end
            wait_frames(rd + 1, 700);
            check_frame(rd, tbl[i].exp_l, tbl[i].exp_r, tbl[i].exp_ur);
            rd++;
        end

        // Nothing offered: three zero frames, one underrun each.
        apply_reset();
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (underrun) cnt++;
        end
        check("idle_underrun_pulses", cnt, 3);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("idle_underrun_cnt", 32'(underrun_cnt), 32'd3);
`endif
        check_frame(0, 24'h0, 24'h0, 1'b1);

        // in_valid held high across four frames.
        apply_reset();
        idx = 0; cnt = 0; ready_hi = 0; c = 0;
        in_valid = 1'b1;
        in_left  = 24'd1;
        in_right = 24'h800001;
        while (mon_count < 4 && c < 1400) begin
            will_xfer = in_valid && in_ready;
            tick();
            c++;
            if (underrun) cnt++;
            if (in_ready && in_valid) ready_hi++;
            if (will_xfer) begin
                idx++;
                if (idx == 4) in_valid = 1'b0;
                else begin
                    in_left  = 24'(idx + 1);
                    in_right = 24'h800000 | 24'(idx + 1);
                end
            end
        end
        if (mon_count < 4) timeout("stream_frames");
        check("stream_underruns", cnt, 0);
        check("stream_ready_high_cycles", ready_hi, 3);
        for (int i = 0; i < 4; i++)
            check_frame(i, 24'(i + 1), 24'h800000 | 24'(i + 1), 1'b0);

        // Offer lands exactly on the frame-start edge with hold empty.
        apply_reset();
        repeat (7) tick();
        in_valid = 1'b1;
        in_left  = 24'h5A5A5A;
        in_right = 24'h0F0F0F;
        tick();
        in_valid = 1'b0;
        check("start_edge_underrun", 32'(underrun), 32'd1);
        wait_frames(2, 700);
        check_frame(0, 24'h0, 24'h0, 1'b1);
        check_frame(1, 24'h5A5A5A, 24'h0F0F0F, 1'b0);

        // Asynchronous reset at p=10 while bit_clk and sd are high.
        apply_reset();
        in_valid = 1'b1;
        in_left  = 24'hA5F00F;
        in_right = 24'h800001;
        tick();
        in_valid = 1'b0;
        c = 0;
        while (!(exp_p() == 10 && exp_bclk()) && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) timeout("reach_p10");
        check("pre_reset_bclk_sd", {30'd0, bit_clk, sd}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {27'd0, bit_clk, lr_clk, sd, in_ready, underrun}, 32'd2);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("async_reset_cnt", 32'(underrun_cnt), 32'd0);
`endif
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        startup_seq();

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_left  = 24'($urandom);
            in_right = 24'($urandom);
            tick();
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
I2S bus master and transmitter. This is the driving end of the mic-array interface that the beamformer top receives: it generates bit_clk and lr_clk from the system clock and serializes stereo PCM frames onto one data line. It feeds beamformer inputs in loopback benches and on-board mic emulation. It accepts frames through a valid/ready handshake into a one-entry holding register and transmits zeros on underrun.

Parameters:
SAMPLE_W, 24, bits per channel sample; requires 1 <= SAMPLE_W <= SLOT_W
SLOT_W, 32, bit_clk periods per channel slot; the frame is 2*SLOT_W bits
CLK_DIV, 4, clk cycles per bit_clk half-period; requires CLK_DIV >= 2

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a frame is offered on in_left/in_right
in_ready  output  1  the holding register is empty, so the frame is accepted this cycle
in_left  input  SAMPLE_W  left sample, two's complement, MSB first on the wire
in_right  input  SAMPLE_W  right sample
bit_clk  output  1  serial bit clock
lr_clk  output  1  word select; 0 = left, 1 = right
sd  output  1  serial data; changes on bit_clk falling edges only
underrun  output  1  one-clk pulse when a frame starts and the holding register is empty

Behaviour:
- Divider: counter runs 0..CLK_DIV-1. At CLK_DIV-1, bit_clk toggles and the counter returns to 0. The bit_clk period is 2*CLK_DIV clk cycles.
- Fall event: the clk cycle in which bit_clk toggles 1->0. bit_clk, lr_clk and sd are all registered; lr_clk and sd update only on fall events.
- Position counter p runs 0..2*SLOT_W-1 and advances by 1 (wrapping) on each fall event.
- lr_clk = 1 when p is in [SLOT_W-1, 2*SLOT_W-2], else 0. This is standard I2S: word select leads data by one bit.
- Left bit k (k=0 is MSB) goes out at p = 1+k. Right bit k goes out at p = (SLOT_W+1+k) mod 2*SLOT_W. All other positions drive sd = 0.
- If SAMPLE_W = SLOT_W, the right LSB goes out at p = 0 of the next frame, taken from the previous frame's shifter.
- Frame start: the fall event on which p goes 0->1. Both left and right shifters load together from the holding register, so a frame is always coherent.
  - If the holding register is empty, both shifters load zeros and underrun pulses high for exactly that cycle.
- Handshake:
  - in_ready = !hold_full, registered.
  - A transfer happens when in_valid && in_ready. hold_full sets on the next edge.
  - hold_full clears on frame start.
  - No bypass: a transfer in the same cycle as a frame start with an empty holding register still produces an underrun. The frame accepted that cycle goes out in the following frame.
  - in_left/in_right are don't-care when in_valid = 0.
- Reset: bit_clk=0, lr_clk=0, sd=0, underrun=0, in_ready=1, divider=0, p=2*SLOT_W-1, shifters=0, hold empty.
  - Reset asserted mid-frame aborts immediately. There is no partial-frame completion.
  - The first fall event after release takes p to 0. The second one is the first frame start.
- Steady state: one frame per 4*SLOT_W*CLK_DIV clk cycles. A producer that holds in_valid high never underruns.

Optional Feature:
I2S_TX_UNDERRUN_CNT_EN
- Defined: adds output underrun_cnt, 8 bits, reset 0. It increments on each underrun pulse and saturates at 255. It is readable any time; underrun behaviour is otherwise unchanged.
- Undefined: the port and counter are absent.

Test Plan:
All scenarios use SAMPLE_W=24, SLOT_W=32, CLK_DIV=2 unless stated.
- Reset release -> bit_clk rises at clk edge 2 and falls at edge 4, period 4 clks. lr_clk=0. Left MSB first appears at clk edge 8 after release.
- Prefill in_left=24'hA5F00F, in_right=24'h800001 -> sd carries the left word at p=1..24 and the right word at p=33..56, with zeros elsewhere. lr_clk rises at p=31 and falls at p=63. in_ready=0 until the next frame start.
- No frame offered -> the first frame is all zeros and underrun pulses once per frame start. With I2S_TX_UNDERRUN_CNT_EN defined, underrun_cnt reads 3 after 3 frames.
- in_valid held high for 4 frames with values 1,2,3,4 -> the four frames go out in order with no underrun. in_ready is low for all but one clk per frame.
- in_valid asserted in the exact frame-start cycle with hold empty -> underrun=1 and that frame is zeros. The offered sample appears in the next frame.
- rst_n asserted at p=10 of a frame -> all outputs are at reset values asynchronously. After release, the sequence restarts exactly as in the first scenario.
